// File: rtl/secam_seq_pkg.sv
// rtl/secam_seq_pkg.sv - shared types for the SECAM chroma line sequencer
package secam_seq_pkg;

  // Line phase of the sequencer
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FLUSH,
    ST_ACTIVE
  } seq_state_e;

  // Sideband address field is sized for the largest supported line; the top
  // narrows it to ADDR_W on the way out.
  localparam int SB_ADDR_W = 16;

  typedef logic signed [8:0] chroma_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_dr;
    logic [SB_ADDR_W-1:0] addr;
    logic                 last;
  } sideband_t;

endpackage

// File: rtl/secam_seq_delay.sv
// rtl/secam_seq_delay.sv - fixed-depth sideband delay line with synchronous flush
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   flush_i     : clears every stage on the next edge (line abort)
//   sb_i        : sideband entering the delay line
//   sb_o        : sideband DEPTH cycles later
module secam_seq_delay
  import secam_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush_i,
  input  sideband_t sb_i,
  output sideband_t sb_o
);

  sideband_t pipe_q [DEPTH];
  sideband_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = flush_i ? sideband_t'('0) : sb_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = flush_i ? sideband_t'('0) : pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) pipe_q[i] <= sideband_t'('0);
      else        pipe_q[i] <= pipe_d[i];
    end
  end

  assign sb_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/secam_chroma_sequencer.sv
// rtl/secam_chroma_sequencer.sv - SECAM chroma deemphasis line sequencer
//
// Tracks horizontal position from newline strobes, holds the Db/Dr line
// identity, clears the deemphasis filter before each active window, gates
// chroma into the filter and emits sideband aligned to the filter output.
//
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   newline_i        : hsync leading-edge pulse (restarts the line, aborts any line in flight)
//   newframe_i       : frame-start pulse, re-phases the Db/Dr identity
//   first_line_dr_i  : identity of the first line of the frame (1 = Dr)
//   chroma_i         : demodulated chroma, one sample per cycle
//   filt_clear       : filter state clear
//   filt_in          : gated filter input
//   out_valid/out_is_dr/out_addr/out_last : sideband aligned to filter output
module secam_chroma_sequencer
  import secam_seq_pkg::*;
#(
  parameter int H_COUNT_W      = 11,
  parameter int ACTIVE_START   = 160,
  parameter int ACTIVE_LEN     = 640,
  parameter int FLUSH_LEN      = 8,
  parameter int FILTER_LATENCY = 4,
  parameter int ADDR_W         = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newline_i,
  input  logic              newframe_i,
  input  logic              first_line_dr_i,
  input  logic signed [8:0] chroma_i,
  output logic              filt_clear,
  output logic signed [8:0] filt_in,
  output logic              out_valid,
  output logic              out_is_dr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam logic [H_COUNT_W-1:0] FLUSH_AT = H_COUNT_W'(ACTIVE_START - FLUSH_LEN);
  localparam logic [H_COUNT_W-1:0] ACT_AT   = H_COUNT_W'(ACTIVE_START);
  localparam logic [H_COUNT_W-1:0] LAST_AT  = H_COUNT_W'(ACTIVE_START + ACTIVE_LEN - 1);

  seq_state_e           state_q, state_d, eff_state;
  logic [H_COUNT_W-1:0] cnt_q, cnt_d;
  logic                 dr_q, dr_d;
  logic                 pend_q, pend_d;
  logic                 pend_dr_q, pend_dr_d;
  logic                 filt_clear_q, filt_clear_d;
  chroma_t              filt_in_q, filt_in_d;
  sideband_t            sb0_q, sb0_d;
  sideband_t            sb_out;
  logic                 accept;

  always_comb begin
    // The transition threshold applies in the same cycle the counter reaches
    // it, so the effective state is resolved combinationally first.
    eff_state = state_q;
    case (state_q)
      ST_WAIT:  if (cnt_q == FLUSH_AT) eff_state = ST_FLUSH;
      ST_FLUSH: if (cnt_q == ACT_AT)   eff_state = ST_ACTIVE;
      default:  ;
    endcase
    accept = (eff_state == ST_ACTIVE);

    state_d = eff_state;
    if (accept && cnt_q == LAST_AT) state_d = ST_IDLE;

    cnt_d = cnt_q;
    if (state_q != ST_IDLE && cnt_q != '1) cnt_d = cnt_q + H_COUNT_W'(1);

    dr_d         = dr_q;
    pend_d       = pend_q;
    pend_dr_d    = pend_dr_q;
    filt_clear_d = (eff_state == ST_FLUSH);
    filt_in_d    = accept ? chroma_i : chroma_t'('0);
    sb0_d        = sideband_t'('0);
    if (accept) begin
      sb0_d.valid = 1'b1;
      sb0_d.is_dr = dr_q;
      sb0_d.addr  = SB_ADDR_W'(cnt_q - ACT_AT);
      sb0_d.last  = (cnt_q == LAST_AT);
    end

    if (newline_i) begin
      // A newline always restarts the line; anything in flight is dropped.
      state_d      = ST_WAIT;
      cnt_d        = '0;
      filt_clear_d = 1'b0;
      filt_in_d    = '0;
      sb0_d        = sideband_t'('0);
      pend_d       = 1'b0;
      if (newframe_i)  dr_d = first_line_dr_i;
      else if (pend_q) dr_d = pend_dr_q;
      else             dr_d = ~dr_q;
    end else if (newframe_i) begin
      pend_d    = 1'b1;
      pend_dr_d = first_line_dr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dr_q         <= 1'b1;
      pend_q       <= 1'b0;
      pend_dr_q    <= 1'b0;
      filt_clear_q <= 1'b0;
      filt_in_q    <= '0;
      sb0_q        <= sideband_t'('0);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dr_q         <= dr_d;
      pend_q       <= pend_d;
      pend_dr_q    <= pend_dr_d;
      filt_clear_q <= filt_clear_d;
      filt_in_q    <= filt_in_d;
      sb0_q        <= sb0_d;
    end
  end

  secam_seq_delay #(
    .DEPTH (FILTER_LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (newline_i),
    .sb_i    (sb0_q),
    .sb_o    (sb_out)
  );

  // Upper address bits are always zero for legal ACTIVE_LEN
  logic unused_addr_bits;
  assign unused_addr_bits = ^sb_out.addr;

  assign filt_clear = filt_clear_q;
  assign filt_in    = filt_in_q;
  assign out_valid  = sb_out.valid;
  assign out_is_dr  = sb_out.is_dr;
  assign out_addr   = sb_out.addr[ADDR_W-1:0];
  assign out_last   = sb_out.last;

endmodule
